// File: rtl/rf_port_arb.sv
// Port arbiter/sequencer for the 16x16 register file: shares the read/write ports between the
// pipeline and a debug requester, and streams R1..R15 out of read port 1 when the core halts.
module rf_port_arb #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // Pipeline side
  input  logic [3:0]  pl_p0_addr_i,
  input  logic [3:0]  pl_p1_addr_i,
  input  logic        pl_re0_i,
  input  logic        pl_re1_i,
  input  logic [3:0]  pl_dst_addr_i,
  input  logic [15:0] pl_dst_i,
  input  logic        pl_we_i,
  input  logic        hlt_i,
  output logic        pl_stall_o,
  // Debug side
  input  logic        dbg_req_i,
  input  logic        dbg_wr_i,
  input  logic [3:0]  dbg_addr_i,
  input  logic [15:0] dbg_wdata_i,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [15:0] dbg_rdata_o,
  // Register file side
  output logic [3:0]  rf_p0_addr_o,
  output logic [3:0]  rf_p1_addr_o,
  output logic        rf_re0_o,
  output logic        rf_re1_o,
  output logic [3:0]  rf_dst_addr_o,
  output logic [15:0] rf_dst_o,
  output logic        rf_we_o,
  input  logic [15:0] rf_p1_i,
  // Dump stream
  output logic        dump_valid_o,
  output logic [3:0]  dump_idx_o,
  output logic [15:0] dump_data_o,
  output logic        dump_done_o
);

  typedef enum logic [1:0] {StRun, StDump, StHalted} state_e;

  localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        dbg_rvalid_q, dbg_rvalid_d;
  logic [15:0] dbg_rdata_q, dbg_rdata_d;
  logic        dump_valid_q, dump_valid_d;
  logic [3:0]  dump_idx_q, dump_idx_d;
  logic [15:0] dump_data_q, dump_data_d;
  logic        dump_done_q, dump_done_d;

  logic pl_live, pl_re0_live, pl_re1_live, pl_we_live;
  logic conflict, wait_full, gnt;

  // Pipeline requests only count while running and not yet halting.
  always_comb begin
    pl_live     = (state_q == StRun) && !hlt_i;
    pl_re0_live = pl_re0_i && pl_live;
    pl_re1_live = pl_re1_i && pl_live;
    pl_we_live  = pl_we_i && pl_live && rst_ni;
    conflict    = dbg_wr_i ? pl_we_live : pl_re1_live;
    wait_full   = (wait_cnt_q == MaxWaitC);
    gnt         = rst_ni && dbg_req_i && (state_q != StDump) && (!conflict || wait_full);
  end

  assign dbg_gnt_o  = gnt;
  assign pl_stall_o = gnt && conflict;

  // RF port steering: pipeline passthrough, overridden by dump walk and debug grants.
  always_comb begin
    rf_p0_addr_o  = pl_p0_addr_i;
    rf_p1_addr_o  = pl_p1_addr_i;
    rf_re0_o      = pl_re0_live;
    rf_re1_o      = pl_re1_live;
    rf_dst_addr_o = pl_dst_addr_i;
    rf_dst_o      = pl_dst_i;
    rf_we_o       = pl_we_live;

    if (state_q == StDump) begin
      rf_p1_addr_o = idx_q;
      rf_re1_o     = 1'b1;
      rf_re0_o     = 1'b0;
    end

    if (gnt) begin
      if (dbg_wr_i) begin
        rf_dst_addr_o = dbg_addr_i;
        rf_dst_o      = dbg_wdata_i;
        rf_we_o       = 1'b1;
      end else begin
        rf_p1_addr_o = dbg_addr_i;
        rf_re1_o     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_cnt_d   = 4'd0;
    dump_valid_d = 1'b0;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;
    dump_done_d  = 1'b0;
    dbg_rvalid_d = gnt && !dbg_wr_i;
    dbg_rdata_d  = dbg_rvalid_d ? rf_p1_i : dbg_rdata_q;

    unique case (state_q)
      StRun: begin
        if (dbg_req_i && !gnt) begin
          wait_cnt_d = wait_full ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
        if (hlt_i) begin
          state_d = StDump;
          idx_d   = 4'd1;
        end
      end
      StDump: begin
        if (!hlt_i) begin
          state_d = StRun;
        end else begin
          dump_valid_d = 1'b1;
          dump_idx_d   = idx_q;
          dump_data_d  = rf_p1_i;
          if (idx_q == 4'd15) begin
            state_d = StHalted;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StHalted: begin
        if (!hlt_i) begin
          state_d = StRun;
        end else begin
          dump_done_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StRun;
      wait_cnt_q   <= 4'd0;
      idx_q        <= 4'd0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= 16'd0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= 4'd0;
      dump_data_q  <= 16'd0;
      dump_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      idx_q        <= idx_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
      dump_done_q  <= dump_done_d;
    end
  end

  assign dbg_rvalid_o = dbg_rvalid_q;
  assign dbg_rdata_o  = dbg_rdata_q;
  assign dump_valid_o = dump_valid_q;
  assign dump_idx_o   = dump_idx_q;
  assign dump_data_o  = dump_data_q;
  assign dump_done_o  = dump_done_q;

endmodule

// File: tb/tb_rf_port_arb.sv
// Bench for rf_port_arb: models the register file contents and debug/dump behaviour at the
// transaction level and compares DUT outputs against that model.
module tb_rf_port_arb;

  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pl_p0_addr, pl_p1_addr, pl_dst_addr, dbg_addr;
  logic        pl_re0, pl_re1, pl_we, hlt, dbg_req, dbg_wr;
  logic [15:0] pl_dst, dbg_wdata;
  logic        pl_stall, dbg_gnt, dbg_rvalid;
  logic [15:0] dbg_rdata;
  logic [3:0]  rf_p0_addr, rf_p1_addr, rf_dst_addr;
  logic        rf_re0, rf_re1, rf_we;
  logic [15:0] rf_dst, rf_p1;
  logic        dump_valid, dump_done;
  logic [3:0]  dump_idx;
  logic [15:0] dump_data;

  int checks = 0;
  int failures = 0;

  logic [15:0] rf_mem [16];
  logic [15:0] model  [16];

  rf_port_arb #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pl_p0_addr_i(pl_p0_addr), .pl_p1_addr_i(pl_p1_addr),
    .pl_re0_i(pl_re0), .pl_re1_i(pl_re1),
    .pl_dst_addr_i(pl_dst_addr), .pl_dst_i(pl_dst), .pl_we_i(pl_we),
    .hlt_i(hlt), .pl_stall_o(pl_stall),
    .dbg_req_i(dbg_req), .dbg_wr_i(dbg_wr), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .rf_p0_addr_o(rf_p0_addr), .rf_p1_addr_o(rf_p1_addr),
    .rf_re0_o(rf_re0), .rf_re1_o(rf_re1),
    .rf_dst_addr_o(rf_dst_addr), .rf_dst_o(rf_dst), .rf_we_o(rf_we),
    .rf_p1_i(rf_p1),
    .dump_valid_o(dump_valid), .dump_idx_o(dump_idx), .dump_data_o(dump_data),
    .dump_done_o(dump_done)
  );

  always #5 clk = ~clk;

  // Register file stand-in: R0 reads zero and ignores writes.
  assign rf_p1 = (rf_p1_addr == 4'd0) ? 16'h0000 : rf_mem[rf_p1_addr];
  always @(posedge clk) if (rf_we && rf_dst_addr != 4'd0) rf_mem[rf_dst_addr] <= rf_dst;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pl_re0 = 0; pl_re1 = 0; pl_we = 0; dbg_req = 0; dbg_wr = 0; hlt = 0;
    pl_p0_addr = 0; pl_p1_addr = 0; pl_dst_addr = 0; pl_dst = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  // Runs one debug request; reports what the DUT did without judging it.
  task automatic dbg_xact(input logic wr, input logic [3:0] addr, input logic [15:0] wdata,
                          input logic conflict, input logic [3:0] pl_addr,
                          input logic [15:0] pl_data, output int lat, output logic stall,
                          output logic rv, output logic [15:0] rd);
    step();
    idle();
    dbg_req = 1; dbg_wr = wr; dbg_addr = addr; dbg_wdata = wdata;
    if (conflict) begin
      if (wr) begin
        pl_we = 1; pl_dst_addr = pl_addr; pl_dst = pl_data;
      end else begin
        pl_re1 = 1; pl_p1_addr = pl_addr;
      end
    end
    lat = -1;
    stall = 0;
    for (int c = 0; c < int'(MAX_WAIT) + 4; c++) begin
      if (c != 0) step();
      @(negedge clk);
      if (dbg_gnt) begin
        lat = c;
        stall = pl_stall;
        break;
      end
    end
    step();
    idle();
    @(negedge clk);
    rv = dbg_rvalid;
    rd = dbg_rdata;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    pl_p0_addr = 4'd9; pl_re0 = 1; pl_we = 1; pl_dst_addr = 4'd2; dbg_req = 1; dbg_wr = 1;
    #2;
    checks++;
    if ({pl_stall, dbg_gnt, dbg_rvalid, dump_valid, dump_done, rf_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000",
               {pl_stall, dbg_gnt, dbg_rvalid, dump_valid, dump_done, rf_we});
    end
    checks++;
    if ({dbg_rdata, dump_data, dump_idx} !== 36'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {dbg_rdata, dump_data, dump_idx});
    end
    checks++;
    if ({rf_p0_addr, rf_dst_addr} !== {4'd9, 4'd2}) begin
      failures++;
      $display("FAIL reset_passthrough got=%h exp=92", {rf_p0_addr, rf_dst_addr});
    end
    step();
    rst_n = 1;
    idle();
  endtask

  task automatic test_dbg_read();
    step();
    pl_we = 1; pl_dst_addr = 4'd5; pl_dst = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({rf_we, rf_dst_addr, rf_dst} !== {1'b1, 4'd5, 16'hBEEF}) begin
      failures++;
      $display("FAIL pl_write_pass got=%h exp=%h", {rf_we, rf_dst_addr, rf_dst},
               {1'b1, 4'd5, 16'hBEEF});
    end
    model[5] = 16'hBEEF;
    step();
    idle();
    dbg_req = 1; dbg_addr = 4'd5; pl_re0 = 1; pl_p0_addr = 4'd5;
    @(negedge clk);
    checks++;
    if ({dbg_gnt, pl_stall, rf_re1, rf_p1_addr, rf_re0} !== {1'b1, 1'b0, 1'b1, 4'd5, 1'b1}) begin
      failures++;
      $display("FAIL rd_grant got=%b exp=1010101", {dbg_gnt, pl_stall, rf_re1, rf_p1_addr, rf_re0});
    end
    step();
    idle();
    @(negedge clk);
    checks++;
    if ({dbg_rvalid, dbg_rdata} !== {1'b1, 16'hBEEF}) begin
      failures++;
      $display("FAIL rd_data got=%h exp=1beef", {dbg_rvalid, dbg_rdata});
    end
    step();
    @(negedge clk);
    checks++;
    if (dbg_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_rvalid_pulse got=%b exp=0", dbg_rvalid);
    end
  endtask

  task automatic test_forced_write();
    int lat;
    logic st, rv;
    logic [15:0] rd;
    step();
    idle();
    pl_we = 1; pl_dst_addr = 4'd7; pl_dst = 16'h7777;
    dbg_req = 1; dbg_wr = 1; dbg_addr = 4'd3; dbg_wdata = 16'h1234;
    for (int c = 0; c <= int'(MAX_WAIT); c++) begin
      if (c != 0) step();
      @(negedge clk);
      checks++;
      if (c < int'(MAX_WAIT)) begin
        if ({dbg_gnt, pl_stall, rf_we, rf_dst_addr} !== {3'b001, 4'd7}) begin
          failures++;
          $display("FAIL wr_wait c=%0d got=%b exp=0017", c, {dbg_gnt, pl_stall, rf_we, rf_dst_addr});
        end
      end else if ({dbg_gnt, pl_stall, rf_we, rf_dst_addr, rf_dst} !== {3'b111, 4'd3, 16'h1234})
      begin
        failures++;
        $display("FAIL wr_forced got=%h exp=%h", {dbg_gnt, pl_stall, rf_we, rf_dst_addr, rf_dst},
                 {3'b111, 4'd3, 16'h1234});
      end
    end
    model[7] = 16'h7777;
    model[3] = 16'h1234;
    dbg_xact(1'b0, 4'd3, 16'h0, 1'b0, 4'd0, 16'h0, lat, st, rv, rd);
    checks++;
    if ({rv, rd} !== {1'b1, 16'h1234}) begin
      failures++;
      $display("FAIL wr_readback got=%h exp=11234", {rv, rd});
    end
  endtask

  task automatic test_r0_write();
    int lat;
    logic st, rv;
    logic [15:0] rd;
    dbg_xact(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0, lat, st, rv, rd);
    checks++;
    if (lat != 0) begin
      failures++;
      $display("FAIL r0_grant lat=%0d exp=0", lat);
    end
    dbg_xact(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, lat, st, rv, rd);
    checks++;
    if ({rv, rd} !== {1'b1, 16'h0000}) begin
      failures++;
      $display("FAIL r0_read got=%h exp=10000", {rv, rd});
    end
  endtask

  task automatic test_random();
    int lat, exp_lat;
    logic st, rv, wr, conf;
    logic [3:0] addr, pa;
    logic [15:0] wd, pd, rd, exp_rd;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      conf = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
      pa = 4'($urandom_range(1, 15));
      wd = 16'($urandom);
      pd = 16'($urandom);
      exp_lat = conf ? int'(MAX_WAIT) : 0;
      exp_rd = model[addr];
      dbg_xact(wr, addr, wd, conf, pa, pd, lat, st, rv, rd);
      checks++;
      if (lat != exp_lat || st !== conf) begin
        failures++;
        $display("FAIL rand_grant n=%0d lat=%0d stall=%b exp_lat=%0d exp_stall=%b",
                 n, lat, st, exp_lat, conf);
      end
      checks++;
      if (!wr && {rv, rd} !== {1'b1, exp_rd}) begin
        failures++;
        $display("FAIL rand_read n=%0d addr=%0d got=%h exp=%h", n, addr, {rv, rd}, {1'b1, exp_rd});
      end else if (wr && rv !== 1'b0) begin
        failures++;
        $display("FAIL rand_wr_rvalid n=%0d got=%b exp=0", n, rv);
      end
      if (wr && conf) model[pa] = pd;
      if (wr && addr != 4'd0) model[addr] = wd;
    end
  endtask

  task automatic test_dump();
    int first, beats, last, done_cyc;
    logic we_seen;
    for (int i = 1; i < 16; i++) begin
      step();
      pl_we = 1; pl_dst_addr = 4'(i); pl_dst = 16'h1000 + 16'(i);
      model[i] = 16'h1000 + 16'(i);
    end
    step();
    idle();
    hlt = 1; pl_we = 1; pl_dst_addr = 4'd9; pl_dst = 16'hDEAD;
    first = -1; beats = 0; last = -1; done_cyc = -1; we_seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (c != 0) step();
      @(negedge clk);
      if (rf_we) we_seen = 1;
      if (dump_valid) begin
        if (first < 0) first = c;
        checks++;
        if (beats >= 15) begin
          failures++;
          $display("FAIL dump_extra_beat idx=%0d exp=none", dump_idx);
        end else if ({dump_idx, dump_data} !== {4'(beats + 1), model[beats + 1]}) begin
          failures++;
          $display("FAIL dump_beat got=%h exp=%h", {dump_idx, dump_data},
                   {4'(beats + 1), model[beats + 1]});
        end
        beats++;
        last = c;
      end
      if (dump_done && done_cyc < 0) done_cyc = c;
    end
    checks++;
    if (first != 2 || beats != 15 || done_cyc != last + 1) begin
      failures++;
      $display("FAIL dump_timing first=%0d beats=%0d done=%0d exp first=2 beats=15 done=%0d",
               first, beats, done_cyc, last + 1);
    end
    checks++;
    if (we_seen !== 1'b0 || dump_done !== 1'b1) begin
      failures++;
      $display("FAIL dump_hold we_seen=%b done=%b exp we_seen=0 done=1", we_seen, dump_done);
    end
    step();
    hlt = 0; pl_dst_addr = 4'd0;
    step();
    @(negedge clk);
    checks++;
    if ({dump_done, rf_we} !== 2'b01) begin
      failures++;
      $display("FAIL dump_exit got=%b exp=01", {dump_done, rf_we});
    end
    step();
    idle();
  endtask

  task automatic test_dump_abort();
    int beats, drop_cyc;
    logic drop_next, dropped, done_seen;
    step();
    idle();
    hlt = 1; pl_we = 1; pl_dst_addr = 4'd0; pl_dst = 16'hDEAD;
    beats = 0; drop_cyc = -1; drop_next = 0; dropped = 0; done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (c != 0) step();
      if (drop_next) begin
        hlt = 0; drop_next = 0; dropped = 1; drop_cyc = c;
      end
      @(negedge clk);
      if (dump_valid) beats++;
      if (dump_done) done_seen = 1;
      if (dropped && (c == drop_cyc || c == drop_cyc + 1)) begin
        checks++;
        if (rf_we !== (c == drop_cyc + 1)) begin
          failures++;
          $display("FAIL abort_pass c=%0d got=%b exp=%b", c - drop_cyc, rf_we, c == drop_cyc + 1);
        end
      end
      if (beats == 5 && !dropped) drop_next = 1;
    end
    checks++;
    if (beats != 6 || done_seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_beats got=%0d done=%b exp=6 done=0", beats, done_seen);
    end
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    int lat, l2;
    logic st, rv;
    logic [15:0] rd;
    step();
    idle();
    hlt = 1;
    for (int c = 0; c < 4; c++) step();
    @(negedge clk);
    #2;
    rst_n = 0;
    hlt = 0;
    #1;
    checks++;
    if ({dump_valid, dump_done, dbg_rvalid, pl_stall, dbg_gnt} !== 5'b0 ||
        {dump_idx, dump_data, dbg_rdata} !== 36'h0) begin
      failures++;
      $display("FAIL rst_mid_dump got=%b/%h exp=0/0",
               {dump_valid, dump_done, dbg_rvalid, pl_stall, dbg_gnt},
               {dump_idx, dump_data, dbg_rdata});
    end
    step();
    rst_n = 1;
    step();
    dbg_req = 1; dbg_wr = 1; dbg_addr = 4'd11; dbg_wdata = 16'h5A5A;
    pl_we = 1; pl_dst_addr = 4'd0;
    step();
    step();
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({dbg_gnt, pl_stall, rf_we} !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid_wait got=%b exp=000", {dbg_gnt, pl_stall, rf_we});
    end
    step();
    rst_n = 1;
    lat = -1;
    for (int c = 0; c < int'(MAX_WAIT) + 4; c++) begin
      if (c != 0) step();
      @(negedge clk);
      if (dbg_gnt) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != int'(MAX_WAIT)) begin
      failures++;
      $display("FAIL rst_fresh_wait lat=%0d exp=%0d", lat, MAX_WAIT);
    end
    model[11] = 16'h5A5A;
    dbg_xact(1'b0, 4'd11, 16'h0, 1'b0, 4'd0, 16'h0, l2, st, rv, rd);
    checks++;
    if ({rv, rd} !== {1'b1, model[11]}) begin
      failures++;
      $display("FAIL rst_readback got=%h exp=%h", {rv, rd}, {1'b1, model[11]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 16'h0;
      model[i] = 16'h0;
    end
    test_reset();
    test_dbg_read();
    test_forced_write();
    test_r0_write();
    test_random();
    test_dump();
    test_dump_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_port_arb.md
# rf_port_arb

Arbiter and sequencer for the 16x16 triple-ported register file (2 read ports, 1 write port; R0 hardwired zero; writes on clk high, reads on clk low). Shares the RF ports between the pipeline and a debug requester with bounded debug wait. On halt, it walks R1..R15 out of read port 1 as a registered dump stream, replacing simulation-only dumping. Sits between the decode/writeback stages and the RF instance.

## Interface
- MAX_WAIT, 4: cycles a blocked debug request waits before it is forced through with a pipeline stall; legal range 1..15.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pl_p0_addr, pl_p1_addr  in  4 each  pipeline read addresses
- pl_re0, pl_re1  in  1 each  pipeline read enables
- pl_dst_addr  in  4  pipeline write address
- pl_dst  in  16  pipeline write data
- pl_we  in  1  pipeline write enable
- hlt  in  1  pipeline halted (level)
- pl_stall  out  1  pipeline must hold and re-present this cycle's RF request
- dbg_req  in  1  debug access request (level, held until dbg_gnt)
- dbg_wr  in  1  1 = write, 0 = read
- dbg_addr  in  4  debug register address
- dbg_wdata  in  16  debug write data
- dbg_gnt  out  1  request accepted this cycle
- dbg_rvalid  out  1  dbg_rdata valid (registered, 1 cycle)
- dbg_rdata  out  16  debug read data
- rf_p0_addr, rf_p1_addr  out  4 each  to RF read addresses
- rf_re0, rf_re1  out  1 each  to RF read enables
- rf_dst_addr  out  4 / rf_dst  out  16 / rf_we  out  1  to RF write port
- rf_p1  in  16  RF read port 1 data
- dump_valid  out  1  dump_data valid for dump_idx
- dump_idx  out  4  register index of dump_data
- dump_data  out  16  dumped register value
- dump_done  out  1  dump complete, held while hlt

## Operation
- FSM states: RUN, DUMP, HALTED. Reset -> RUN.
- RUN: RF outputs pass the pipeline signals through combinationally unless debug is granted.
  - Debug read uses port 1 only; it conflicts iff pl_re1=1. Debug write conflicts iff pl_we=1.
  - No conflict: dbg_gnt=1 in the same cycle as dbg_req. The debug request drives port 1 (rf_p1_addr=dbg_addr, rf_re1=1) or the write port (rf_dst_addr/rf_dst/rf_we=1). pl_stall=0.
  - Conflict: pipeline wins. wait_cnt increments each cycle that dbg_req=1 and dbg_gnt=0, saturating at MAX_WAIT.
  - When wait_cnt==MAX_WAIT, debug is granted and pl_stall=1 for that cycle. The conflicting pipeline port is suppressed; non-conflicting ports still pass through.
  - wait_cnt clears on grant and whenever dbg_req=0.
- Debug read data: at the posedge ending the grant cycle, capture rf_p1 into dbg_rdata; dbg_rvalid=1 for the next cycle only.
- Debug write to R0 is granted normally; the RF ignores the write.
- hlt rising (hlt=1 while in RUN) -> DUMP with idx=1.
  - Pipeline inputs are ignored from the cycle hlt is seen: rf_we=0 unless debug.
  - A debug grant in flight completes; no new grants are issued in DUMP.
- DUMP: each cycle drives rf_p1_addr=idx, rf_re1=1, rf_re0=0. At the posedge, register dump_data=rf_p1, dump_idx=idx, dump_valid=1, then idx++. After idx=15 is issued -> HALTED.
- HALTED: dump_done=1. Debug requests are granted immediately with no conflict and pl_stall=0. hlt=0 -> RUN, and dump_done clears the same cycle.
- hlt deasserted during DUMP: abort to RUN the next cycle, remaining indices skipped, dump_done never set.

## Timing
- Reset values: pl_stall=0, dbg_gnt=0, dbg_rvalid=0, dbg_rdata=0, dump_valid=0, dump_idx=0, dump_data=0, dump_done=0, wait_cnt=0, state RUN. The rf_* outputs equal the pipeline passthrough, except rf_we=0.
- rst_n low at any point, including mid-dump, returns everything to reset values immediately.
- dbg_gnt and pl_stall are combinational from registered state and current inputs. Every other debug/dump output is registered.
- Read latency: dbg_rvalid rises 1 cycle after dbg_gnt.
- Worst-case debug wait: grant in cycle MAX_WAIT counted from request (0-based).
- Dump: first dump_valid 2 cycles after the first cycle hlt=1 is sampled. 15 consecutive dump_valid beats (idx 1..15). dump_done rises the cycle after the last beat.

## Test plan
- Debug read R5 with pl_re1=0 while the RF holds R5=16'hBEEF -> dbg_gnt same cycle, pl_stall=0; next cycle dbg_rvalid=1, dbg_rdata=16'hBEEF.
- Debug write R3=16'h1234 with pl_we=1 held, MAX_WAIT=4 -> no grant in cycles 0-3; cycle 4 dbg_gnt=1, pl_stall=1, rf_we=1, rf_dst_addr=3; a later read of R3 returns 16'h1234.
- Debug write R0=16'hFFFF with no conflict -> granted; a read of R0 returns 16'h0000.
- Load R1..R15 = 16'h1000+i, then assert hlt -> 15 beats dump_idx=1..15, dump_data=16'h1001..16'h100F, then dump_done=1 while hlt is held; pipeline pl_we=1 during the dump produces no rf_we.
- hlt dropped after 6 dump beats -> RUN, dump_done stays 0, passthrough resumes the next cycle.
- rst_n pulsed low mid-dump and mid-wait -> all outputs at reset values asynchronously; after release, a fresh request is granted with wait_cnt from 0.
